// File: rtl/knn_ctrl_pkg.sv
// Shared definitions for the k-NN pass sequencer: state encodings, pipeline depth
// and the default coordinate, label and address widths.
package knn_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_FETCH = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int KNN_PIPE_DEPTH = 3;

    localparam int KNN_COORD_W = 16;
    localparam int KNN_LABEL   = 8;
    localparam int KNN_ADDR_W  = 10;

endpackage

// File: rtl/knn_dist.sv
// Squared-Euclidean distance pipeline with a valid bit travelling beside the data;
// candidates appear three cycles after the matching RAM read enable.
module knn_dist
    import knn_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int COORD_W = KNN_COORD_W,
    parameter int LABEL   = KNN_LABEL
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue,
    input  logic signed [COORD_W-1:0] test_x,
    input  logic signed [COORD_W-1:0] test_y,
    input  logic signed [COORD_W-1:0] mem_x,
    input  logic signed [COORD_W-1:0] mem_y,
    input  logic        [LABEL-1:0]   mem_label,
    output logic                      out_valid,
    output logic        [DATA_W-1:0]  out_dist,
    output logic        [LABEL-1:0]   out_label
);

    localparam int SQ_W  = 2 * COORD_W + 2;
    localparam int SUM_W = 2 * COORD_W + 3;

    logic                      rd_valid;
    logic                      s1_valid;
    logic signed [COORD_W:0]   s1_dx;
    logic signed [COORD_W:0]   s1_dy;
    logic        [LABEL-1:0]   s1_label;

    logic signed [SQ_W-1:0]    dx_w;
    logic signed [SQ_W-1:0]    dy_w;
    logic        [SQ_W-1:0]    sq_x;
    logic        [SQ_W-1:0]    sq_y;
    logic        [SUM_W-1:0]   sum;
    logic        [DATA_W-1:0]  dist_next;

    // The RAM read itself is the first cycle of latency, so squaring is folded
    // into the summing stage to keep mem_en-to-candidate at three cycles.
    always_comb begin
        dx_w      = SQ_W'(s1_dx);
        dy_w      = SQ_W'(s1_dy);
        sq_x      = $unsigned(dx_w * dx_w);
        sq_y      = $unsigned(dy_w * dy_w);
        sum       = SUM_W'(sq_x) + SUM_W'(sq_y);
        dist_next = (|sum[SUM_W-1:DATA_W]) ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid  <= 1'b0;
            s1_valid  <= 1'b0;
            s1_dx     <= '0;
            s1_dy     <= '0;
            s1_label  <= '0;
            out_valid <= 1'b0;
            out_dist  <= '0;
            out_label <= '0;
        end else begin
            rd_valid  <= issue;
            s1_valid  <= rd_valid;
            out_valid <= s1_valid;
            if (rd_valid) begin
                s1_dx    <= {mem_x[COORD_W-1], mem_x} - {test_x[COORD_W-1], test_x};
                s1_dy    <= {mem_y[COORD_W-1], mem_y} - {test_y[COORD_W-1], test_y};
                s1_label <= mem_label;
            end
            if (s1_valid) begin
                out_dist  <= dist_next;
                out_label <= s1_label;
            end
        end
    end

endmodule

// File: rtl/knn_ctrl.sv
// Sequencer for one k-NN pass: clears the neighbour list, streams every training
// point through the distance pipeline and pulses done once the list is final.
module knn_ctrl
    import knn_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int COORD_W = KNN_COORD_W,
    parameter int LABEL   = KNN_LABEL,
    parameter int ADDR_W  = KNN_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      go,
    input  logic        [ADDR_W:0]    n_points,
    input  logic signed [COORD_W-1:0] test_x,
    input  logic signed [COORD_W-1:0] test_y,
    output logic                      mem_en,
    output logic        [ADDR_W-1:0]  mem_addr,
    input  logic signed [COORD_W-1:0] mem_x,
    input  logic signed [COORD_W-1:0] mem_y,
    input  logic        [LABEL-1:0]   mem_label,
    output logic                      list_start,
    output logic                      list_valid,
    output logic        [DATA_W-1:0]  list_dist,
    output logic        [LABEL-1:0]   list_label,
    output logic                      busy,
    output logic                      done
);

    localparam int DRAIN_W = $clog2(KNN_PIPE_DEPTH);
    localparam logic [ADDR_W:0] N_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic        [2:0]         state;
    logic        [ADDR_W-1:0]  cnt;
    logic        [ADDR_W:0]    cnt_max;
    logic        [ADDR_W:0]    n_clamped;
    logic        [DRAIN_W-1:0] drain_cnt;
    logic signed [COORD_W-1:0] tx;
    logic signed [COORD_W-1:0] ty;
    logic                      last_fetch;

    always_comb begin
        n_clamped  = (n_points > N_MAX) ? N_MAX : n_points;
        last_fetch = ({1'b0, cnt} == (cnt_max - (ADDR_W + 1)'(1)));
    end

    assign list_start = (state == ST_CLEAR);
    assign mem_en     = (state == ST_FETCH);
    assign mem_addr   = cnt;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);

    // go is only looked at in IDLE, so pulses during a pass (DONE included) fall away.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cnt_max   <= '0;
            drain_cnt <= '0;
            tx        <= '0;
            ty        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) state <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    tx        <= test_x;
                    ty        <= test_y;
                    cnt_max   <= n_clamped;
                    cnt       <= '0;
                    drain_cnt <= '0;
                    state     <= (n_clamped != '0) ? ST_FETCH : ST_DRAIN;
                end
                ST_FETCH: begin
                    cnt <= cnt + ADDR_W'(1);
                    if (last_fetch) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_W'(KNN_PIPE_DEPTH - 1)) state <= ST_DONE;
                    else drain_cnt <= drain_cnt + DRAIN_W'(1);
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    knn_dist #(
        .DATA_W  (DATA_W),
        .COORD_W (COORD_W),
        .LABEL   (LABEL)
    ) u_dist (
        .clk       (clk),
        .rst       (rst),
        .issue     (mem_en),
        .test_x    (tx),
        .test_y    (ty),
        .mem_x     (mem_x),
        .mem_y     (mem_y),
        .mem_label (mem_label),
        .out_valid (list_valid),
        .out_dist  (list_dist),
        .out_label (list_label)
    );

endmodule
